pipe_mem: RTL and testbench

PIPE_MEM -- requirements
Module: pipe_MEM

---
 rtl/pipe_mem_pkg.sv | 30 +++
 rtl/pipe_mem_ex_mem_reg.sv | 54 +++++
 rtl/pipe_mem.sv | 143 ++++++++++++++
 tb/tb_pipe_mem.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_mem_pkg.sv
// Shared definitions for the MEM pipeline stage.
//   - Width constants for register numbers, data words and the stall counter.
//   - Encoding of the data-memory handshake FSM states.
//   - Saturating increment used by the stall counter.
package pipe_mem_pkg;

  localparam int REGN_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  // Add one unless already at the top, so the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

endpackage

// File: rtl/pipe_mem_ex_mem_reg.sv
// EX/MEM pipeline register with a load enable.
// Ports:
//   clk, clrn            - clock, synchronous active-high clear
//   en                   - load enable (low while the MEM stage is stalled)
//   ex_wreg/m2reg/wmem   - EX-stage register-write, load and store controls
//   ex_wn, ex_alu, ex_di - destination register, ALU result/address, store data
//   m_*                  - the same fields as held in the MEM stage
module pipe_mem_ex_mem_reg
  import pipe_mem_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              en,
  input  logic              ex_wreg,
  input  logic              ex_m2reg,
  input  logic              ex_wmem,
  input  logic [REGN_W-1:0] ex_wn,
  input  logic [DATA_W-1:0] ex_alu,
  input  logic [DATA_W-1:0] ex_di,
  output logic              m_wreg,
  output logic              m_m2reg,
  output logic              m_wmem,
  output logic [REGN_W-1:0] m_wn,
  output logic [DATA_W-1:0] m_alu,
  output logic [DATA_W-1:0] m_di
);

  // Capture the EX fields when enabled; otherwise hold the instruction in MEM.
  always_ff @(posedge clk) begin
    if (clrn) begin
      m_wreg  <= 1'b0;
      m_m2reg <= 1'b0;
      m_wmem  <= 1'b0;
      m_wn    <= {REGN_W{1'b0}};
      m_alu   <= {DATA_W{1'b0}};
      m_di    <= {DATA_W{1'b0}};
    end else if (en) begin
      m_wreg  <= ex_wreg;
      m_m2reg <= ex_m2reg;
      m_wmem  <= ex_wmem;
      m_wn    <= ex_wn;
      m_alu   <= ex_alu;
      m_di    <= ex_di;
    end else begin
      m_wreg  <= m_wreg;
      m_m2reg <= m_m2reg;
      m_wmem  <= m_wmem;
      m_wn    <= m_wn;
      m_alu   <= m_alu;
      m_di    <= m_di;
    end
  end

endmodule

// File: rtl/pipe_mem.sv
// MEM stage of the pipeline: issues data-memory requests, stalls upstream
// stages until the memory acknowledges, and feeds the MEM/WB register.
// Ports:
//   clk, clrn                      - clock, synchronous active-high reset
//   EXwreg, EXm2reg, EXwmem        - EX-stage controls (write reg, load, store)
//   EXwn, EXaluResult, EXdi        - destination reg, address/result, store data
//   stall                          - freezes upstream stages while high
//   dm_req, dm_we, dm_addr, dm_wdata - data-memory request
//   dm_ack, dm_rdata               - data-memory completion and load data
//   WBwreg, WBm2reg, WBwn, WBaluResult, WBmo - writeback fields
//   stall_cnt                      - saturating count of stalled cycles
module pipe_mem
  import pipe_mem_pkg::*;
(
  input  logic              clk,
  input  logic              clrn,
  input  logic              EXwreg,
  input  logic              EXm2reg,
  input  logic              EXwmem,
  input  logic [REGN_W-1:0] EXwn,
  input  logic [DATA_W-1:0] EXaluResult,
  input  logic [DATA_W-1:0] EXdi,
  output logic              stall,
  output logic              dm_req,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic              dm_ack,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              WBwreg,
  output logic              WBm2reg,
  output logic [REGN_W-1:0] WBwn,
  output logic [DATA_W-1:0] WBaluResult,
  output logic [DATA_W-1:0] WBmo,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              mwreg_s;
  logic              mm2reg_s;
  logic              mwmem_s;
  logic [REGN_W-1:0] mwn_s;
  logic [DATA_W-1:0] malu_s;
  logic [DATA_W-1:0] mdi_s;
  logic              memop_s;
  logic              stall_s;
  mem_state_t        state_r;
  mem_state_t        state_nxt_s;

  pipe_mem_ex_mem_reg u_ex_mem_reg (
    .clk      (clk),
    .clrn     (clrn),
    .en       (~stall_s),
    .ex_wreg  (EXwreg),
    .ex_m2reg (EXm2reg),
    .ex_wmem  (EXwmem),
    .ex_wn    (EXwn),
    .ex_alu   (EXaluResult),
    .ex_di    (EXdi),
    .m_wreg   (mwreg_s),
    .m_m2reg  (mm2reg_s),
    .m_wmem   (mwmem_s),
    .m_wn     (mwn_s),
    .m_alu    (malu_s),
    .m_di     (mdi_s)
  );

  // A zero-wait ack lets the access complete in its issue cycle, so the
  // stall is combinational on dm_ack rather than derived from the FSM state.
  assign memop_s  = mm2reg_s | mwmem_s;
  assign stall_s  = memop_s & ~dm_ack;
  assign stall    = stall_s;
  assign dm_req   = memop_s;
  assign dm_we    = mwmem_s;
  assign dm_addr  = malu_s;
  assign dm_wdata = mdi_s;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (clrn) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Handshake next-state: wait out a memory access that was not acked at once.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (memop_s && !dm_ack) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (dm_ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // MEM/WB register: advance the instruction, or insert a bubble while stalled.
  // An instruction flagged both load and store is a store, so it never writes back.
  always_ff @(posedge clk) begin
    if (clrn) begin
      WBwreg      <= 1'b0;
      WBm2reg     <= 1'b0;
      WBwn        <= {REGN_W{1'b0}};
      WBaluResult <= {DATA_W{1'b0}};
      WBmo        <= {DATA_W{1'b0}};
    end else if (!stall_s) begin
      WBwreg      <= mwreg_s & ~(mm2reg_s & mwmem_s);
      WBm2reg     <= mm2reg_s;
      WBwn        <= mwn_s;
      WBaluResult <= malu_s;
      WBmo        <= mm2reg_s ? dm_rdata : WBmo;
    end else begin
      WBwreg      <= 1'b0;
      WBm2reg     <= 1'b0;
      WBwn        <= WBwn;
      WBaluResult <= WBaluResult;
      WBmo        <= WBmo;
    end
  end

  // Stall-cycle counter, sticks at all-ones.
  always_ff @(posedge clk) begin
    if (clrn) begin
      stall_cnt <= {CNT_W{1'b0}};
    end else if (stall_s) begin
      stall_cnt <= sat_inc(stall_cnt);
    end else begin
      stall_cnt <= stall_cnt;
    end
  end

endmodule

// File: tb/tb_pipe_mem.sv
// Self-checking bench for pipe_mem: directed scenarios plus randomized
// instruction streams, checked against a cycle-level reference model of the
// MEM slot, the writeback fields and the stall counter.
module tb_pipe_mem;
  import pipe_mem_pkg::*;

  logic        clk = 1'b0;
  logic        clrn;
  logic        EXwreg, EXm2reg, EXwmem;
  logic [4:0]  EXwn;
  logic [31:0] EXaluResult, EXdi;
  logic        stall, dm_req, dm_we, dm_ack;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        WBwreg, WBm2reg;
  logic [4:0]  WBwn;
  logic [31:0] WBaluResult, WBmo;
  logic [15:0] stall_cnt;

  pipe_mem dut (
    .clk(clk), .clrn(clrn),
    .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem),
    .EXwn(EXwn), .EXaluResult(EXaluResult), .EXdi(EXdi),
    .stall(stall), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .WBwreg(WBwreg), .WBm2reg(WBm2reg), .WBwn(WBwn),
    .WBaluResult(WBaluResult), .WBmo(WBmo), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wreg;
    logic        m2reg;
    logic        wmem;
    logic [4:0]  wn;
    logic [31:0] alu;
    logic [31:0] di;
  } instr_t;

  localparam instr_t NOP = '0;

  // reference model state
  instr_t      ex_q = NOP;
  instr_t      m_q  = NOP;
  int          ex_lat = 0;
  int          m_lat  = 0;
  logic        e_wreg = 1'b0, e_m2reg = 1'b0;
  logic [4:0]  e_wn = 5'd0;
  logic [31:0] e_alu = 32'd0, e_mo = 32'd0;
  int          e_cnt = 0;
  bit          ex_taken = 1'b0;
  bit          force_ack = 1'b0;
  bit          rd_fix_en = 1'b0;
  logic [31:0] rd_fix = 32'd0;
  int          stall_seen = 0;
  int          req_seen = 0;

  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic instr_t mk(input bit wreg, input bit m2reg, input bit wmem,
                                input logic [4:0] wn, input logic [31:0] alu,
                                input logic [31:0] di);
    instr_t r;
    r.wreg = wreg; r.m2reg = m2reg; r.wmem = wmem;
    r.wn = wn; r.alu = alu; r.di = di;
    return r;
  endfunction

  // One clock cycle: drive at the falling edge, check, then advance the model.
  task automatic cycle(input bit rst);
    bit          memop, ack, st;
    logic [31:0] rd;
    @(negedge clk);
    memop = m_q.m2reg | m_q.wmem;
    if (force_ack)  ack = 1'b1;
    else if (memop) ack = (m_lat <= 0);
    else            ack = ($urandom_range(0, 1) == 1);
    rd = rd_fix_en ? rd_fix : $urandom;
    clrn = rst;
    EXwreg = ex_q.wreg; EXm2reg = ex_q.m2reg; EXwmem = ex_q.wmem;
    EXwn = ex_q.wn; EXaluResult = ex_q.alu; EXdi = ex_q.di;
    dm_ack = ack; dm_rdata = rd;
    #1;
    st = memop & ~ack;
    if (stall)  stall_seen++;
    if (dm_req) req_seen++;
    check_val("stall",  32'(stall),  32'(st));
    check_val("dm_req", 32'(dm_req), 32'(memop));
    if (memop) begin
      check_val("dm_we",    32'(dm_we), 32'(m_q.wmem));
      check_val("dm_addr",  dm_addr,    m_q.alu);
      check_val("dm_wdata", dm_wdata,   m_q.di);
    end
    check_val("WBwreg",      32'(WBwreg),    32'(e_wreg));
    check_val("WBm2reg",     32'(WBm2reg),   32'(e_m2reg));
    check_val("WBwn",        32'(WBwn),      32'(e_wn));
    check_val("WBaluResult", WBaluResult,    e_alu);
    check_val("WBmo",        WBmo,           e_mo);
    check_val("stall_cnt",   32'(stall_cnt), 32'(e_cnt));
    @(posedge clk);
    if (rst) begin
      m_q = NOP; m_lat = 0;
      e_wreg = 1'b0; e_m2reg = 1'b0; e_wn = 5'd0; e_alu = 32'd0; e_mo = 32'd0;
      e_cnt = 0;
    end else if (st) begin
      if (e_cnt < 65535) e_cnt++;
      e_wreg = 1'b0; e_m2reg = 1'b0;
      m_lat--;
    end else begin
      e_wreg  = m_q.wreg & ~(m_q.m2reg & m_q.wmem);
      e_m2reg = m_q.m2reg;
      e_wn    = m_q.wn;
      e_alu   = m_q.alu;
      if (m_q.m2reg) e_mo = rd;
      m_q = ex_q; m_lat = ex_lat;
    end
    ex_taken = !rst && !st;
  endtask

  // Present an instruction in EX and hold it until the MEM stage accepts it.
  task automatic issue(input instr_t ins, input int lat);
    int guard;
    guard = 0;
    ex_q = ins; ex_lat = lat;
    do begin
      cycle(1'b0);
      guard++;
    end while (!ex_taken && guard < 70000);
    if (!ex_taken) check_val("issue_timeout", 32'd0, 32'd1);
    ex_q = NOP; ex_lat = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0);
  endtask

  initial begin
    clrn = 1'b1; EXwreg = 1'b0; EXm2reg = 1'b0; EXwmem = 1'b0; EXwn = 5'd0;
    EXaluResult = 32'd0; EXdi = 32'd0; dm_ack = 1'b0; dm_rdata = 32'd0;
    cycle(1'b1);
    cycle(1'b1);
    #2;
    check_val("rst_WBwreg",    32'(WBwreg),    32'd0);
    check_val("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    check_val("rst_dm_req",    32'(dm_req),    32'd0);

    // ALU op reaches WB two edges after EX, without stalling
    stall_seen = 0;
    issue(mk(1'b1, 1'b0, 1'b0, 5'd5, 32'h12, 32'h0), 0);
    cycle(1'b0);
    #2;
    check_val("alu_WBwreg", 32'(WBwreg), 32'd1);
    check_val("alu_WBwn",   32'(WBwn),   32'd5);
    check_val("alu_WBalu",  WBaluResult, 32'h12);
    check_val("alu_nostall", 32'(stall_seen), 32'd0);

    // zero-wait load
    stall_seen = 0; req_seen = 0;
    rd_fix_en = 1'b1; rd_fix = 32'hDEADBEEF;
    issue(mk(1'b1, 1'b1, 1'b0, 5'd9, 32'h100, 32'h0), 0);
    cycle(1'b0);
    rd_fix_en = 1'b0;
    #2;
    check_val("ld0_WBmo",    WBmo,             32'hDEADBEEF);
    check_val("ld0_WBm2reg", 32'(WBm2reg),     32'd1);
    check_val("ld0_nostall", 32'(stall_seen),  32'd0);
    check_val("ld0_req1",    32'(req_seen),    32'd1);

    // store with ack after three cycles
    stall_seen = 0; req_seen = 0;
    issue(mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h40, 32'hA5A5), 3);
    idle(5);
    check_val("st3_stalls",    32'(stall_seen), 32'd3);
    check_val("st3_req_cyc",   32'(req_seen),   32'd4);
    check_val("st3_stall_cnt", 32'(stall_cnt),  32'd3);

    // reset while a load waits, then a late ack
    issue(mk(1'b1, 1'b1, 1'b0, 5'd4, 32'h300, 32'h0), 5);
    cycle(1'b0);
    cycle(1'b1);
    force_ack = 1'b1;
    cycle(1'b0);
    force_ack = 1'b0;
    #2;
    check_val("rw_dm_req",  32'(dm_req),      32'd0);
    check_val("rw_WBwreg",  32'(WBwreg),      32'd0);
    check_val("rw_WBm2reg", 32'(WBm2reg),     32'd0);
    check_val("rw_WBwn",    32'(WBwn),        32'd0);
    check_val("rw_WBalu",   WBaluResult,      32'd0);
    check_val("rw_WBmo",    WBmo,             32'd0);
    check_val("rw_idle",    32'(dut.state_r), 32'd0);

    // back-to-back load (ack after one cycle) then ALU op
    issue(mk(1'b1, 1'b1, 1'b0, 5'd3, 32'h200, 32'h0), 1);
    issue(mk(1'b1, 1'b0, 1'b0, 5'd7, 32'h77, 32'h0), 0);
    #2;
    check_val("b2b_ld_WBm2reg", 32'(WBm2reg), 32'd1);
    check_val("b2b_ld_WBwn",    32'(WBwn),    32'd3);
    cycle(1'b0);
    #2;
    check_val("b2b_alu_WBwreg",  32'(WBwreg),  32'd1);
    check_val("b2b_alu_WBm2reg", 32'(WBm2reg), 32'd0);
    check_val("b2b_alu_WBwn",    32'(WBwn),    32'd7);
    check_val("b2b_alu_WBalu",   WBaluResult,  32'h77);

    // randomized instruction stream, including both-flags stores and resets
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 49);
      if (kind == 0) begin
        cycle(1'b1);
      end else if (kind < 5) begin
        idle($urandom_range(1, 3));
      end else begin
        issue(mk(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
                 $urandom, $urandom), $urandom_range(0, 3));
      end
    end
    idle(6);

    // stall counter saturation
    issue(mk(1'b1, 1'b1, 1'b0, 5'd1, 32'h500, 32'h0), 65540);
    idle(65542);
    check_val("sat_cnt", 32'(stall_cnt), 32'hFFFF);
    issue(mk(1'b0, 1'b0, 1'b1, 5'd0, 32'h600, 32'h1), 2);
    idle(4);
    check_val("sat_nowrap", 32'(stall_cnt), 32'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
